seq_divider: RTL



---
 rtl/divider_pkg.sv | 39 +++
 rtl/divider_step.sv | 26 ++
 rtl/seq_divider.sv | 107 ++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared widths, FSM state type and a reference divide model for the sequential divider.
package divider_pkg;

    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic                      div_zero;
        logic [DEF_DIVISOR_W-1:0]  remainder;
        logic [DEF_DIVIDEND_W-1:0] quotient;
    } div_result_t;

    // Golden model at the default widths; divide-by-zero mirrors the hardware convention.
    function automatic div_result_t ref_div(input logic [DEF_DIVIDEND_W-1:0] dividend,
                                            input logic [DEF_DIVISOR_W-1:0]  divisor);
        div_result_t               res;
        logic [DEF_DIVIDEND_W-1:0] wide_divisor;
        logic [DEF_DIVIDEND_W-1:0] wide_rem;
        wide_divisor = {{(DEF_DIVIDEND_W-DEF_DIVISOR_W){1'b0}}, divisor};
        if (divisor == '0) begin
            res.quotient  = '1;
            res.remainder = dividend[DEF_DIVISOR_W-1:0];
            res.div_zero  = 1'b1;
        end else begin
            wide_rem      = dividend % wide_divisor;
            res.quotient  = dividend / wide_divisor;
            res.remainder = wide_rem[DEF_DIVISOR_W-1:0];
            res.div_zero  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift {R,Q} left, trial-subtract, restore on borrow.
module divider_step
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]    r,
    input  logic [DIVIDEND_W-1:0] q,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVISOR_W:0]    r_next,
    output logic [DIVIDEND_W-1:0] q_next
);

    // One spare bit on top so a borrow shows up as the sign of the trial value.
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] trial;
    logic                 borrow;

    assign shifted = {r, q[DIVIDEND_W-1]};
    assign trial   = shifted - {2'b00, divisor};
    assign borrow  = trial[DIVISOR_W+1];
    assign r_next  = borrow ? shifted[DIVISOR_W:0] : trial[DIVISOR_W:0];
    assign q_next  = {q[DIVIDEND_W-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int             CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    div_state_t            state, state_next;
    logic [CNT_W-1:0]      count;
    logic [DIVISOR_W:0]    r_reg, r_next;
    logic [DIVIDEND_W-1:0] q_reg, q_next;
    logic [DIVISOR_W-1:0]  dvsr;

    divider_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_step (
        .r       (r_reg),
        .q       (q_reg),
        .divisor (dvsr),
        .r_next  (r_next),
        .q_next  (q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (divisor == '0) ? DONE : BUSY;
            end
            BUSY: begin
                if (count == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers only load on entry to DONE, so they stay stable through a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg     <= '0;
            q_reg     <= '0;
            dvsr      <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend[DIVISOR_W-1:0];
                            div_zero  <= 1'b1;
                        end else begin
                            r_reg <= '0;
                            q_reg <= dividend;
                            dvsr  <= divisor;
                            count <= '0;
                        end
                    end
                end
                BUSY: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        quotient  <= q_next;
                        remainder <= r_next[DIVISOR_W-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
